// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StStretch,
    StRelease,
    StRun
  } state_e;

  localparam int unsigned DefNumSrc     = 4;
  localparam int unsigned DefNumDom     = 3;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefStretch    = 16;
  localparam int unsigned DefDomGap     = 8;

  localparam int unsigned CntWidth = 16;
  localparam int unsigned IdxWidth = 3;

endpackage

// File: rtl/rst_seq_ctrl_sync_ff.sv
// Single-bit multi-flop synchroniser with synchronous clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: collects reset requests, holds all domains in reset, then
// releases them one at a time in ascending order.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_SRC     = DefNumSrc,
  parameter int unsigned NUM_DOM     = DefNumDom,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned STRETCH     = DefStretch,
  parameter int unsigned DOM_GAP     = DefDomGap
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_SRC-1:0] rst_req,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_rst,
  input  logic               cause_clr,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic [NUM_SRC:0]   rst_cause,
  output logic               busy
);

  localparam logic [CntWidth-1:0] StretchLast = CntWidth'(STRETCH - 1);
  localparam logic [CntWidth-1:0] GapLast     = CntWidth'(DOM_GAP - 1);
  localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);
  localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(NUM_DOM - 1);

  logic [NUM_SRC-1:0] req_sync;
  logic [NUM_SRC-1:0] req_s;
  logic               any_req;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [NUM_DOM-1:0]  dom_q, dom_d;
  logic [NUM_SRC:0]    cause_q, cause_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    sync_ff #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(Clk),
      .rst(Rst),
      .d  (rst_req[i]),
      .q  (req_sync[i])
    );
  end

  // Masking after the synchroniser keeps mask changes glitch-free on req_s.
  assign req_s   = req_sync & src_mask;
  assign any_req = (|req_s) | sw_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    if (any_req) begin
      state_d = StAssert;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '1;
    end else begin
      unique case (state_q)
        StAssert: begin
          state_d = StStretch;
          cnt_d   = '0;
        end
        StStretch: begin
          if (cnt_q == StretchLast) begin
            dom_d[0] = 1'b0;
            cnt_d    = '0;
            idx_d    = IdxWidth'(1);
            state_d  = (NUM_DOM == 1) ? StRun : StRelease;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRelease: begin
          if (cnt_q == GapLast) begin
            for (int i = 0; i < NUM_DOM; i++) begin
              if (idx_q == IdxWidth'(i)) dom_d[i] = 1'b0;
            end
            cnt_d = '0;
            if (idx_q == LastIdx) begin
              state_d = StRun;
            end else begin
              idx_d = idx_q + IdxWidth'(1);
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRun: begin
          dom_d = '0;
        end
        default: begin
          state_d = StAssert;
          dom_d   = '1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A new cause in the same cycle as a clear must survive.
  always_comb begin
    cause_d = cause_clr ? '0 : cause_q;
    cause_d = cause_d | {sw_rst, req_s};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      cause_q <= cause_d;
    end
  end

  assign dom_rst   = dom_q;
  assign dom_rst_n = ~dom_q;
  assign rst_cause = cause_q;
  assign busy      = (state_q != StRun);

endmodule
